grf_mp: RTL and testbench

Parametrised multi-port general register file, successor to the single-write/two-read GRF in the CPU datapath. It provides NUM_RD combinational read ports and two write ports with same-cycle write-to-read forwarding. Storage is cleared by a sequential init engine (one entry per cycle) so it can map to distributed RAM. An optional per-register busy scoreboard supports issue-stage hazard checks.

---
 rtl/grf_pkg.sv | 12 +
 rtl/grf_fwd_mux.sv | 29 ++
 rtl/grf_mp.sv | 136 +++++++++++++
 tb/tb_grf_mp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared types and default widths for the multi-port register file.
package grf_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } grf_state_e;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;

endpackage

// File: rtl/grf_fwd_mux.sv
// One read port: zero/INIT squash, then write-port forwarding, then stored data.
module grf_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              init,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = stored;
    if (init || raddr == '0) begin
      rdata = '0;
    end else if (we1 && waddr1 == raddr) begin
      rdata = wdata1;
    end else if (we0 && waddr0 == raddr) begin
      rdata = wdata0;
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with sequential init clear and write-to-read forwarding.
// Optional busy scoreboard enabled by defining GRF_SCOREBOARD_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_INIT | clearing entry clr_ptr each cycle; writes/alloc ignored
//   ST_RUN  | file usable; clear_req restarts ST_INIT
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int DEPTH = 2 ** ADDR_W;

  grf_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run;
  logic              wr_ok;

  // Outputs are squashed while reset is held, not only after the reset edge.
  assign run   = resetn && (state == ST_RUN);
  assign ready = run;
  assign wr_ok = (state == ST_RUN) && !clear_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_INIT: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (&clr_ptr) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nxt   = ST_INIT;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_INIT;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // No reset on the array so it can map to distributed RAM; port 1 is written last and wins.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == ST_INIT) begin
        mem[clr_ptr] <= '0;
      end else if (wr_ok) begin
        if (we0 && waddr0 != '0) mem[waddr0] <= wdata0;
        if (we1 && waddr1 != '0) mem[waddr1] <= wdata1;
      end
    end
  end

`ifdef GRF_SCOREBOARD_EN
  logic [DEPTH-1:0] busy;

  // Alloc is applied after the write clears so a new producer keeps the entry busy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy <= '0;
    end else if (state == ST_INIT || clear_req) begin
      busy <= '0;
    end else begin
      if (we0) busy[waddr0] <= 1'b0;
      if (we1) busy[waddr1] <= 1'b0;
      if (alloc_en && alloc_addr != '0) busy[alloc_addr] <= 1'b1;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{alloc_en, alloc_addr};
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];

    grf_fwd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_mux (
      .init   (!run),
      .raddr  (ra),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .stored (mem[ra]),
      .rdata  (rdata[k*DATA_W +: DATA_W])
    );

`ifdef GRF_SCOREBOARD_EN
    assign rbusy[k] = run && busy[ra] &&
                      !((we0 && waddr0 == ra) || (we1 && waddr1 == ra));
`else
    assign rbusy[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: vector table, directed corner sequences, random vs. model.
module tb_grf_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;
`ifdef GRF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn, clear_req, ready;
  logic            we0, we1, alloc_en;
  logic [AW-1:0]   waddr0, waddr1, alloc_addr;
  logic [DW-1:0]   wdata0, wdata1;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]  rbusy;

  always #5 clk = ~clk;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) dut (
    .clk(clk), .resetn(resetn), .clear_req(clear_req), .ready(ready),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rbusy(rbusy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: file contents, busy set, and cycles left before the file is usable.
  bit          m_run;
  int          m_left;
  logic [DW-1:0] m_mem [DEPTH];
  bit          m_busy [DEPTH];

  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ra(input int k);
    return raddr[k*AW +: AW];
  endfunction

  function automatic bit hit(input logic [AW-1:0] a);
    return (we0 && waddr0 == a) || (we1 && waddr1 == a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!resetn || !m_run || a == '0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    return SB && resetn && m_run && m_busy[a] && !hit(a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_run  = 1'b0;
    m_left = DEPTH;
  endtask

  task automatic model_step();
    if (!resetn) begin
      model_clear();
    end else if (!m_run) begin
      m_left--;
      if (m_left == 0) m_run = 1'b1;
    end else if (clear_req) begin
      model_clear();
    end else begin
      if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
      if (we0) m_busy[waddr0] = 1'b0;
      if (we1) m_busy[waddr1] = 1'b0;
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("ready", 64'(ready), 64'(resetn && m_run));
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rdata%0d@%0d", k, ra(k)), 64'(rdata[k*DW +: DW]), 64'(exp_rd(ra(k))));
      chk($sformatf("rbusy%0d@%0d", k, ra(k)), 64'(rbusy[k]), 64'(exp_busy(ra(k))));
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    clear_req  = 1'b0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr[0 +: AW]  = a0;
    raddr[AW +: AW] = a1;
  endtask

  // Counts not-ready cycles; with noisy set, writes and allocs are thrown at the file meanwhile.
  task automatic wait_ready(input string name, input bit noisy);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      idle();
      if (noisy) begin
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = $urandom;
        we0 = 1'b1; waddr0 = AW'($urandom_range(1, 31)); wdata0 = $urandom;
        alloc_en = 1'b1; alloc_addr = AW'($urandom_range(1, 31));
      end
      set_ra(AW'(n), AW'(31 - n));
      cycle();
      n++;
    end
    idle();
    chk(name, 64'(n), 64'(32));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd7, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd5, 32'h22, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,  5'd0, 5'd7, 32'h0,  32'h22};
    tbl[5] = '{1'b1, 5'd3, 32'h1234,     1'b1, 5'd3, 32'hCAFE, 5'd3, 5'd0, 32'hCAFE, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd0, 32'hCAFE, 32'h0};

    idle();
    set_ra('0, '0);
    resetn = 1'b0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    set_ra(5'd5, 5'd31);
    cycle();
    cycle();
    resetn = 1'b1;
    wait_ready("init_len_after_reset", 1'b0);

    for (int i = 0; i < 7; i++) begin
      we0 = tbl[i].we0; waddr0 = tbl[i].wa0; wdata0 = tbl[i].wd0;
      we1 = tbl[i].we1; waddr1 = tbl[i].wa1; wdata1 = tbl[i].wd1;
      set_ra(tbl[i].ra0, tbl[i].ra1);
      #1;
      chk($sformatf("vec%0d_rd0", i), 64'(rdata[0 +: DW]), 64'(tbl[i].e0));
      chk($sformatf("vec%0d_rd1", i), 64'(rdata[DW +: DW]), 64'(tbl[i].e1));
      cycle();
    end
    idle();

    for (int a = 1; a < DEPTH; a++) begin
      we0 = 1'b1; waddr0 = AW'(a); wdata0 = 32'h01010101 * a;
      set_ra(AW'(a), AW'(a - 1));
      cycle();
    end
    idle();
    set_ra(5'd17, 5'd31);
    #1;
    chk("filled_r17", 64'(rdata[0 +: DW]), 64'(32'h01010101 * 17));
    clear_req = 1'b1;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hFFFF0000;
    cycle();
    wait_ready("init_len_after_clear", 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      set_ra(AW'(a), AW'(a ^ 1));
      #1;
      chk($sformatf("post_clear_r%0d", a), 64'(rdata[0 +: DW]), 64'(0));
      cycle();
    end

    alloc_en = 1'b1; alloc_addr = 5'd9; set_ra(5'd9, 5'd0);
    cycle();
    idle();
`ifdef GRF_SCOREBOARD_EN
    #1 chk("sb_alloc_busy", 64'(rbusy[0]), 64'(1));
`endif
    cycle();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
`ifdef GRF_SCOREBOARD_EN
    #1 chk("sb_fwd_not_busy", 64'(rbusy[0]), 64'(0));
`endif
    cycle();
    idle();
`ifdef GRF_SCOREBOARD_EN
    #1 chk("sb_cleared", 64'(rbusy[0]), 64'(0));
`endif
    cycle();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hAA;
    cycle();
    idle();
`ifdef GRF_SCOREBOARD_EN
    #1 chk("sb_alloc_wins", 64'(rbusy[0]), 64'(1));
`endif
    cycle();

    clear_req = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 10; i++) cycle();
    resetn = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    wait_ready("init_len_after_mid_init_reset", 1'b0);

    for (int i = 0; i < 3000; i++) begin
      resetn    = ($urandom_range(0, 999) != 0);
      clear_req = ($urandom_range(0, 149) == 0);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      alloc_en = $urandom_range(0, 1);
      waddr0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      waddr1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      alloc_addr = AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      wdata1 = $urandom;
      set_ra(AW'($urandom_range(0, 7)), AW'($urandom));
      cycle();
    end
    idle();
    resetn = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
